seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Passive monitor on the 4-digit multiplexed 7-segment drive lines (segments a..g,dp plus one-hot digit strobes).
- Filters each strobe slot for stability and decodes the segment pattern back to a hex nibble and decimal point.
- Assembles a full 4-digit frame and publishes it with per-digit blank and error flags.
- Used for on-board self-check of display output and as a bench scoreboard front end.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit slot; legal range is >= 1.
- TIMEOUT_CYCLES, 131072, clocks without a complete frame before a partial frame is force-published; legal range is > STABLE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_in  input  8  observed segments: [7:1] = a..g, [0] = dp; active-high
- dig_in  input  4  observed digit strobes, one-hot, active-high; bit k selects position k
- hex_out  output  16  decoded frame; nibble k = position k
- points_out  output  4  decimal point per position
- blank_out  output  4  1 = position was blank or was never seen lit in this frame
- err_out  output  4  1 = position had a lit pattern that is not in the code table
- frame_valid  output  1  one-cycle pulse when hex_out and the flag outputs update

Behaviour:
- Reset: every output is 0. Capture mask, slot storage, stability counter and timeout counter are all 0. The sample register is 0. A partial frame in progress at reset is discarded.
- Sampling: {seg_in, dig_in} is registered every clk into the sample register (1 cycle).
- Qualifying sample: dig has exactly one bit set AND seg != 0. Any non-qualifying sample clears the stability counter and produces no capture.
- Stability counter:
  - Increments while the sample equals the previous sample and qualifies; saturates at STABLE_CYCLES.
  - A change of the sample reloads the counter to 1 if the new sample qualifies, else to 0.
  - Accept fires exactly once per run, on the edge where the counter reaches STABLE_CYCLES.
  - With STABLE_CYCLES = 1, accept fires on the first qualifying sample of each run.
- Decode on accept, using seg[7:1] as hex:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - seg[7:1] = 00 with dp set: hex 0, blank=1, err=0.
  - Any other pattern: hex 0, blank=0, err=1.
  - point = seg[0].
- Slot write: on accept, slot k (the set bit of dig) is written and mask[k] is set. Re-accepting an already-captured position overwrites that slot.
- Normal publish:
  - When mask becomes 1111, the next edge loads all output registers from the slots, pulses frame_valid for 1 cycle, and clears mask and the timeout counter.
  - Latency from the accepting edge to frame_valid high is 1 clk.
- Timeout publish:
  - The timeout counter increments every clk and clears on each publish or reset.
  - On reaching TIMEOUT_CYCLES-1, a publish occurs as above.
  - Positions whose mask bit is 0 publish hex 0, point 0, blank 1, err 0. Mask = 0000 therefore publishes an all-blank frame.
- Simultaneous events: an accept on the same edge as a timeout is merged into the published frame. An accept on the publish edge is recorded into the new, cleared mask and is not lost.
- Outputs hold their values between publishes.

Optional Feature:
- Macro: SEG7_SCAN_SYNC_EN.
- Defined: a 2-flop synchronizer is inserted ahead of the sample register, for use when seg_in/dig_in come from pins or another clock domain. All input-to-accept latencies grow by 2 clk.
- Undefined: inputs are assumed synchronous to clk; only the single sample register is present.

Test Plan:
- Reset, then drive dig=0001/seg=7E, 0010/30, 0100/6D, 1000/79 for 4 clk each -> exactly one frame_valid pulse; hex_out=3210, points=0, blank=0, err=0.
- Same sequence but position 2 held for only 3 clk -> no frame_valid; then position 2 held 4 clk -> frame_valid with hex_out=3210.
- Drive position 1 with seg=0x0B (pattern not in table, dp=1) and the others with valid codes -> err_out=0010, points_out=0010, nibble 1 = 0.
- Drive only positions 0 and 3 (valid, 4 clk each), then hold seg=0 for TIMEOUT_CYCLES -> timeout frame_valid with blank_out=0110 and the captured nibbles correct.
- Assert rst with 3 positions captured, then drive only the 4th position -> no frame_valid until all 4 positions are recaptured.
- Build with SEG7_SCAN_SYNC_EN and repeat test 1 -> identical frame, with frame_valid 2 clk later than in the unsynchronized build.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: passive monitor that decodes 4-digit multiplexed 7-segment drive lines into frames.
// Optional macro SEG7_SCAN_SYNC_EN adds a 2-flop synchronizer ahead of the sample register.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] hex_out,
    output logic [3:0]  points_out,
    output logic [3:0]  blank_out,
    output logic [3:0]  err_out,
    output logic        frame_valid
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    // Returns {err, blank, point, hex}; seg[7:1] = a..g, seg[0] = dp.
    function automatic logic [6:0] decode_seg(input logic [7:0] seg);
        logic [3:0] hex;
        logic       err;
        logic       blank;
        hex   = 4'h0;
        err   = 1'b0;
        blank = 1'b0;
        case (seg[7:1])
            7'h7E:   hex = 4'h0;
            7'h30:   hex = 4'h1;
            7'h6D:   hex = 4'h2;
            7'h79:   hex = 4'h3;
            7'h33:   hex = 4'h4;
            7'h5B:   hex = 4'h5;
            7'h5F:   hex = 4'h6;
            7'h70:   hex = 4'h7;
            7'h7F:   hex = 4'h8;
            7'h7B:   hex = 4'h9;
            7'h77:   hex = 4'hA;
            7'h1F:   hex = 4'hB;
            7'h4E:   hex = 4'hC;
            7'h3D:   hex = 4'hD;
            7'h4F:   hex = 4'hE;
            7'h47:   hex = 4'hF;
            7'h00:   blank = 1'b1;
            default: err = 1'b1;
        endcase
        return {err, blank, seg[0], hex};
    endfunction

    logic [11:0]      samp_d, samp_q;
    logic [11:0]      prev_d, prev_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [TMO_W-1:0] tmo_d, tmo_q;
    logic [3:0]       mask_d, mask_q;
    logic [15:0]      slot_hex_d, slot_hex_q;
    logic [3:0]       slot_pt_d, slot_pt_q;
    logic [3:0]       slot_blk_d, slot_blk_q;
    logic [3:0]       slot_err_d, slot_err_q;
    logic [15:0]      hex_d, hex_q;
    logic [3:0]       pt_d, pt_q;
    logic [3:0]       blk_d, blk_q;
    logic [3:0]       err_d, err_q;
    logic             fv_d, fv_q;

    logic [7:0]  samp_seg_s;
    logic [3:0]  samp_dig_s;
    logic        qual_s;
    logic        same_s;
    logic        accept_s;
    logic [6:0]  dec_s;
    logic [3:0]  mask_wr_s;
    logic        pub_full_s;
    logic        pub_tmo_s;
    logic [3:0]  pub_mask_s;
    logic [15:0] src_hex_s;
    logic [3:0]  src_pt_s;
    logic [3:0]  src_blk_s;
    logic [3:0]  src_err_s;

`ifdef SEG7_SCAN_SYNC_EN
    logic [11:0] sync1_d, sync1_q;
    logic [11:0] sync2_d, sync2_q;

    // Two-stage synchronizer feeding the sample register.
    always_comb begin
        sync1_d = {seg_in, dig_in};
        sync2_d = sync1_q;
        samp_d  = sync2_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 12'h000;
            sync2_q <= 12'h000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
`else
    // Inputs are already synchronous; sample them directly.
    always_comb begin
        samp_d = {seg_in, dig_in};
    end
`endif

    // Stability filter, decode, slot capture and frame publish.
    always_comb begin
        samp_seg_s = samp_q[11:4];
        samp_dig_s = samp_q[3:0];
        qual_s = (samp_dig_s != 4'b0000)
              && ((samp_dig_s & (samp_dig_s - 4'b0001)) == 4'b0000)
              && (samp_seg_s != 8'h00);
        same_s = (samp_q == prev_q);
        prev_d = samp_q;

        if (!qual_s) begin
            cnt_d = '0;
        end else if (!same_s) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // A saturated counter on an unchanged sample means this run was already accepted.
        accept_s = qual_s && (cnt_d == STABLE_MAX) && !(same_s && (cnt_q == STABLE_MAX));

        dec_s      = decode_seg(samp_seg_s);
        mask_wr_s  = 4'b0000;
        slot_hex_d = slot_hex_q;
        slot_pt_d  = slot_pt_q;
        slot_blk_d = slot_blk_q;
        slot_err_d = slot_err_q;
        if (accept_s) begin
            mask_wr_s = samp_dig_s;
            for (int k = 0; k < 4; k++) begin
                if (samp_dig_s[k]) begin
                    slot_hex_d[4*k +: 4] = dec_s[3:0];
                    slot_pt_d[k]         = dec_s[4];
                    slot_blk_d[k]        = dec_s[5];
                    slot_err_d[k]        = dec_s[6];
                end else begin
                    slot_hex_d[4*k +: 4] = slot_hex_q[4*k +: 4];
                end
            end
        end else begin
            mask_wr_s = 4'b0000;
        end

        pub_full_s = (mask_q == 4'hF);
        pub_tmo_s  = !pub_full_s && (tmo_q == TMO_LAST);
        // A timeout publish merges a same-edge accept; a full-frame publish defers it to the next frame.
        if (pub_full_s) begin
            pub_mask_s = 4'hF;
            src_hex_s  = slot_hex_q;
            src_pt_s   = slot_pt_q;
            src_blk_s  = slot_blk_q;
            src_err_s  = slot_err_q;
        end else begin
            pub_mask_s = mask_q | mask_wr_s;
            src_hex_s  = slot_hex_d;
            src_pt_s   = slot_pt_d;
            src_blk_s  = slot_blk_d;
            src_err_s  = slot_err_d;
        end

        hex_d = hex_q;
        pt_d  = pt_q;
        blk_d = blk_q;
        err_d = err_q;
        fv_d  = pub_full_s || pub_tmo_s;
        if (pub_full_s || pub_tmo_s) begin
            for (int k = 0; k < 4; k++) begin
                if (pub_mask_s[k]) begin
                    hex_d[4*k +: 4] = src_hex_s[4*k +: 4];
                    pt_d[k]         = src_pt_s[k];
                    blk_d[k]        = src_blk_s[k];
                    err_d[k]        = src_err_s[k];
                end else begin
                    hex_d[4*k +: 4] = 4'h0;
                    pt_d[k]         = 1'b0;
                    blk_d[k]        = 1'b1;
                    err_d[k]        = 1'b0;
                end
            end
            mask_d = pub_full_s ? mask_wr_s : 4'b0000;
            tmo_d  = '0;
        end else begin
            mask_d = mask_q | mask_wr_s;
            tmo_d  = tmo_q + TMO_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q     <= 12'h000;
            prev_q     <= 12'h000;
            cnt_q      <= '0;
            tmo_q      <= '0;
            mask_q     <= 4'b0000;
            slot_hex_q <= 16'h0000;
            slot_pt_q  <= 4'b0000;
            slot_blk_q <= 4'b0000;
            slot_err_q <= 4'b0000;
            hex_q      <= 16'h0000;
            pt_q       <= 4'b0000;
            blk_q      <= 4'b0000;
            err_q      <= 4'b0000;
            fv_q       <= 1'b0;
        end else begin
            samp_q     <= samp_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            mask_q     <= mask_d;
            slot_hex_q <= slot_hex_d;
            slot_pt_q  <= slot_pt_d;
            slot_blk_q <= slot_blk_d;
            slot_err_q <= slot_err_d;
            hex_q      <= hex_d;
            pt_q       <= pt_d;
            blk_q      <= blk_d;
            err_q      <= err_d;
            fv_q       <= fv_d;
        end
    end

    assign hex_out     = hex_q;
    assign points_out  = pt_q;
    assign blank_out   = blk_q;
    assign err_out     = err_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scan sequences push expected frames, a monitor checks them.
module tb_seg7_scan_decoder;
    logic        clk;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  dig_in;
    logic [15:0] hex_out;
    logic [3:0]  points_out;
    logic [3:0]  blank_out;
    logic [3:0]  err_out;
    logic        frame_valid;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  pts;
        logic [3:0]  blank;
        logic [3:0]  err;
    } frame_t;

    frame_t exp_q[$];
    int     n_vec;
    int     n_err;
    int     cyc;
    int     t_mark;
    logic   lat_chk;
    logic   done;
    logic   rst_prev;

`ifdef SEG7_SCAN_SYNC_EN
    localparam int EXP_LAT = 8;
`else
    localparam int EXP_LAT = 6;
`endif

    seg7_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_in      (dig_in),
        .hex_out     (hex_out),
        .points_out  (points_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic put(input logic [3:0] d, input logic [7:0] s, input int n);
        dig_in = d;
        seg_in = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        seg_in = 8'h00;
        dig_in = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b, input logic [3:0] e);
        frame_t f;
        f.hex   = h;
        f.pts   = p;
        f.blank = b;
        f.err   = e;
        exp_q.push_back(f);
    endtask

    // Monitor: reset-state checks and frame scoreboard.
    always @(negedge clk) begin
        frame_t e;
        if (rst && rst_prev) begin
            n_vec = n_vec + 1;
            if (hex_out !== 16'h0000 || points_out !== 4'h0 || blank_out !== 4'h0
                || err_out !== 4'h0 || frame_valid !== 1'b0) begin
                n_err = n_err + 1;
                $display("FAIL reset_state: got hex=%h pts=%b blank=%b err=%b fv=%b, want all 0",
                         hex_out, points_out, blank_out, err_out, frame_valid);
            end
        end
        rst_prev = rst;
        if (frame_valid === 1'b1) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_frame: got hex=%h pts=%b blank=%b err=%b, want no frame",
                         hex_out, points_out, blank_out, err_out);
            end else begin
                e = exp_q.pop_front();
                if (hex_out !== e.hex || points_out !== e.pts || blank_out !== e.blank || err_out !== e.err) begin
                    n_err = n_err + 1;
                    $display("FAIL frame: got hex=%h pts=%b blank=%b err=%b, want hex=%h pts=%b blank=%b err=%b",
                             hex_out, points_out, blank_out, err_out, e.hex, e.pts, e.blank, e.err);
                end
                if (lat_chk) begin
                    n_vec = n_vec + 1;
                    if (cyc - t_mark != EXP_LAT) begin
                        n_err = n_err + 1;
                        $display("FAIL latency: got %0d clk, want %0d clk", cyc - t_mark, EXP_LAT);
                    end
                end
            end
        end
        if (done) begin
            n_vec = n_vec + 1;
            if (exp_q.size() != 0) begin
                n_err = n_err + 1;
                $display("FAIL missing_frames: got %0d frames outstanding, want 0", exp_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // Directed stimulus.
    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        t_mark   = 0;
        lat_chk  = 1'b0;
        done     = 1'b0;
        rst_prev = 1'b0;
        rst      = 1'b1;
        seg_in   = 8'h00;
        dig_in   = 4'b0000;
        do_reset();

        // Basic frame 3210 with latency measurement on the last position
        push(16'h3210, 4'b0000, 4'b0000, 4'b0000);
        put(4'b0001, 8'hFC, 4);
        put(4'b0010, 8'h60, 4);
        put(4'b0100, 8'hDA, 4);
        t_mark  = cyc;
        lat_chk = 1'b1;
        put(4'b1000, 8'hF2, 4);
        put(4'b0000, 8'h00, 12);
        lat_chk = 1'b0;
        do_reset();

        // Position 2 held 3 clk (rejected), then 4 clk (accepted)
        push(16'h3210, 4'b0000, 4'b0000, 4'b0000);
        put(4'b0001, 8'hFC, 4);
        put(4'b0010, 8'h60, 4);
        put(4'b0100, 8'hDA, 3);
        put(4'b1000, 8'hF2, 4);
        put(4'b0000, 8'h00, 10);
        put(4'b0100, 8'hDA, 4);
        put(4'b0000, 8'h00, 12);
        do_reset();

        // Illegal pattern on position 1, dp on positions 1 and 3
        push(16'h3200, 4'b1010, 4'b0000, 4'b0010);
        put(4'b0001, 8'hFC, 4);
        put(4'b0010, 8'h0B, 4);
        put(4'b0100, 8'hDA, 4);
        put(4'b1000, 8'hF3, 4);
        put(4'b0000, 8'h00, 12);
        do_reset();

        // Letters b, d, F and a dp-only blank digit
        push(16'h0FDB, 4'b1000, 4'b1000, 4'b0000);
        put(4'b0001, 8'h3E, 4);
        put(4'b0010, 8'h7A, 4);
        put(4'b0100, 8'h8E, 4);
        put(4'b1000, 8'h01, 4);
        put(4'b0000, 8'h00, 12);
        do_reset();

        // Partial frame forced out by timeout
        push(16'hA00C, 4'b0000, 4'b0110, 4'b0000);
        put(4'b0001, 8'h9C, 4);
        put(4'b1000, 8'hEE, 4);
        put(4'b0000, 8'h00, 260);
        do_reset();

        // Reset discards a partial frame
        put(4'b0001, 8'h66, 4);
        put(4'b0010, 8'hB6, 4);
        put(4'b0100, 8'hBE, 4);
        do_reset();
        put(4'b1000, 8'hE0, 4);
        put(4'b0000, 8'h00, 20);
        push(16'h7654, 4'b0000, 4'b0000, 4'b0000);
        put(4'b0001, 8'h66, 4);
        put(4'b0010, 8'hB6, 4);
        put(4'b0100, 8'hBE, 4);
        put(4'b1000, 8'hE0, 4);
        put(4'b0000, 8'h00, 12);

        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor_stall: got no summary, want summary");
        $fatal(1);
    end
endmodule
